menu_cursor_ctrl: RTL and testbench
===================================

Name: menu_cursor_ctrl

Overview:
- Upstream controller for the menu-choice cursor sprite.
- Turns keyboard strobes into a selected option index, then drives the cursor sprite's top-left position (posx/posy) and its display-enable (isplay).
- Position changes are applied only at frame boundaries, so the cursor never tears mid-scan.
- Handles blink while selecting, a fast-flash confirm sequence, and a one-cycle confirm pulse to game-state logic.

Parameters:
- NUM_OPTIONS, 3, number of menu entries (2..4).
- BASE_X, 284, cursor posx (constant for all entries).
- BASE_Y, 200, cursor posy for option 0.
- STEP_Y, 48, vertical pitch between options; BASE_Y+(NUM_OPTIONS-1)*STEP_Y must be < 480.
- BLINK_FRAMES, 30, frames per isplay toggle in SELECT.
- FLASH_FRAMES, 4, frames per isplay toggle in FLASH.
- FLASH_COUNT, 6, isplay toggles performed in FLASH.
- HOLDOFF_FRAMES, 8, frames after a move during which further moves are ignored.

Ports:
- clk  in  1  system clock (same domain as vgac)
- rst  in  1  synchronous active-high reset
- frame_tick  in  1  one-cycle pulse per frame from vgac, at start of vertical blank
- menu_active  in  1  level; 1 while the menu screen is shown
- key_up  in  1  level, already synchronised
- key_down  in  1  level, already synchronised
- key_enter  in  1  level, already synchronised
- posx  out  10  cursor left-up x
- posy  out  9  cursor left-up y
- isplay  out  1  cursor sprite enable
- sel  out  2  current selected index
- confirm  out  1  one-cycle pulse when selection is final
- busy  out  1  high in FLASH

Behaviour:
- Reset values: posx=BASE_X, posy=BASE_Y, isplay=0, sel=0, confirm=0, busy=0, state=IDLE, all counters 0, pending move cleared.
- Key edges: each key is registered once; rising edge = key & ~key_q. Level hold produces no repeat.
- IDLE:
  - isplay=0.
  - menu_active=1 -> SELECT, with sel=0, blink counter 0, isplay=1 on the next cycle.
- SELECT:
  - Up edge latches pending=-1; down edge latches pending=+1. Moves are accepted only when the holdoff counter is 0.
  - Up and down edges in the same cycle are ignored.
  - A second edge while a move is pending overwrites it (last edge wins).
  - On frame_tick with a move pending:
    - sel updates.
    - posy = BASE_Y + sel_new*STEP_Y, registered; visible on the cycle after frame_tick.
    - Pending clears.
    - Holdoff loads HOLDOFF_FRAMES.
    - Blink counter resets to 0 and isplay forces to 1.
  - Otherwise each frame_tick decrements holdoff if nonzero. The blink counter increments; on reaching BLINK_FRAMES-1 it wraps to 0 and isplay toggles.
  - Enter edge -> FLASH; any pending move is discarded. Enter has priority over a same-cycle up/down edge.
- FLASH:
  - busy=1; isplay=1 on entry.
  - Toggles every FLASH_FRAMES frame_ticks.
  - After FLASH_COUNT toggles -> DONE, with confirm=1 for exactly that one cycle.
  - Keys are ignored.
- DONE:
  - isplay=1 steady; sel holds.
  - Keys are ignored.
  - menu_active=0 -> IDLE.
- menu_active=0 in any state -> IDLE next cycle. sel, posy, pending and counters reset; isplay=0; confirm is not issued.
- posx is constant BASE_X and never changes.
- sel/posy change only in the cycle following a frame_tick.
- Reset asserted mid-FLASH returns all outputs to reset values next cycle; no confirm pulse.

Optional Feature:
- Macro MENU_WRAP_EN.
- Defined: up from sel=0 goes to NUM_OPTIONS-1; down from NUM_OPTIONS-1 goes to 0.
- Undefined: saturate at the ends. A move that would leave the range is discarded at frame_tick: no sel/posy change, no holdoff load, no blink reset.

Test Plan:
- Reset, then menu_active=1 -> next cycle isplay=1, sel=0, posy=200, posx=284; after 30 frame_ticks isplay=0, after 60 isplay=1.
- Down edge mid-frame -> posy stays 200 until frame_tick, then sel=1, posy=248 the next cycle. A second down edge within 8 frame_ticks is ignored (posy stays 248). A down edge after 8 frame_ticks -> sel=2, posy=296.
- sel=2 plus down edge, with MENU_WRAP_EN -> sel=0, posy=200. Without it -> sel stays 2, posy 296, isplay blink phase undisturbed.
- Up and down edges in the same cycle -> no change at next frame_tick. Enter and down edges in the same cycle -> FLASH, busy=1, sel unchanged.
- Enter at sel=1 -> isplay toggles every 4 frame_ticks, 6 toggles. confirm is high exactly one cycle after the 24th frame_tick and busy drops. DONE holds isplay=1, sel=1. Key edges in FLASH/DONE have no effect.
- menu_active=0 mid-FLASH -> next cycle isplay=0, sel=0, posy=200, busy=0, no confirm. Reset asserted in SELECT with a move pending -> no sel change at the following frame_tick.

Source files
------------

// File: rtl/menu_cursor_ctrl.sv
// Menu cursor controller: turns key strobes into a selected index and drives the cursor
// sprite position/enable at frame boundaries. Define MENU_WRAP_EN to wrap selection at the ends.
module menu_cursor_ctrl #(
  parameter int NUM_OPTIONS    = 3,
  parameter int BASE_X         = 284,
  parameter int BASE_Y         = 200,
  parameter int STEP_Y         = 48,
  parameter int BLINK_FRAMES   = 30,
  parameter int FLASH_FRAMES   = 4,
  parameter int FLASH_COUNT    = 6,
  parameter int HOLDOFF_FRAMES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       menu_active,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_enter,
  output logic [9:0] posx,
  output logic [8:0] posy,
  output logic       isplay,
  output logic [1:0] sel,
  output logic       confirm,
  output logic       busy
);

  localparam int HW = $clog2(HOLDOFF_FRAMES + 1);
  localparam int BW = $clog2(BLINK_FRAMES + 1);
  localparam int FW = $clog2(FLASH_FRAMES + 1);
  localparam int CW = $clog2(FLASH_COUNT + 1);
  localparam logic [1:0] SEL_MAX = 2'(NUM_OPTIONS - 1);
  localparam logic [8:0] POSY0   = 9'(BASE_Y);

  typedef enum logic [1:0] {ST_IDLE, ST_SELECT, ST_FLASH, ST_DONE} state_t;

  function automatic logic [8:0] f_posy(input logic [1:0] s);
    f_posy = 9'(BASE_Y + STEP_Y * int'(s));
  endfunction

  state_t        r_state;
  logic [1:0]    r_sel;
  logic [8:0]    r_posy;
  logic          r_isplay;
  logic          r_confirm;
  logic          r_pend_valid;
  logic          r_pend_down;
  logic [HW-1:0] r_holdoff;
  logic [BW-1:0] r_blink_cnt;
  logic [FW-1:0] r_flash_cnt;
  logic [CW-1:0] r_toggle_cnt;
  logic          r_key_up_q;
  logic          r_key_down_q;
  logic          r_key_enter_q;

  state_t        w_state_next;
  logic [1:0]    w_sel_next;
  logic [8:0]    w_posy_next;
  logic          w_isplay_next;
  logic          w_confirm_next;
  logic          w_pend_valid_next;
  logic          w_pend_down_next;
  logic [HW-1:0] w_holdoff_next;
  logic [BW-1:0] w_blink_cnt_next;
  logic [FW-1:0] w_flash_cnt_next;
  logic [CW-1:0] w_toggle_cnt_next;
  logic          w_apply;
  logic          w_target_ok;
  logic [1:0]    w_target_sel;

  logic w_up_edge;
  logic w_down_edge;
  logic w_enter_edge;

  assign w_up_edge    = key_up & ~r_key_up_q;
  assign w_down_edge  = key_down & ~r_key_down_q;
  assign w_enter_edge = key_enter & ~r_key_enter_q;

  // Destination of the pending move; w_target_ok drops when a saturating move would leave the range.
  always_comb begin
    w_target_ok  = 1'b1;
    w_target_sel = r_sel;
    if (r_pend_down) begin
      if (r_sel == SEL_MAX) begin
`ifdef MENU_WRAP_EN
        w_target_sel = 2'd0;
`else
        w_target_ok  = 1'b0;
`endif
      end else begin
        w_target_sel = r_sel + 2'd1;
      end
    end else begin
      if (r_sel == 2'd0) begin
`ifdef MENU_WRAP_EN
        w_target_sel = SEL_MAX;
`else
        w_target_ok  = 1'b0;
`endif
      end else begin
        w_target_sel = r_sel - 2'd1;
      end
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_sel_next        = r_sel;
    w_posy_next       = r_posy;
    w_isplay_next     = r_isplay;
    w_confirm_next    = 1'b0;
    w_pend_valid_next = r_pend_valid;
    w_pend_down_next  = r_pend_down;
    w_holdoff_next    = r_holdoff;
    w_blink_cnt_next  = r_blink_cnt;
    w_flash_cnt_next  = r_flash_cnt;
    w_toggle_cnt_next = r_toggle_cnt;
    w_apply           = 1'b0;

    if (!menu_active) begin
      w_state_next      = ST_IDLE;
      w_sel_next        = 2'd0;
      w_posy_next       = POSY0;
      w_isplay_next     = 1'b0;
      w_pend_valid_next = 1'b0;
      w_pend_down_next  = 1'b0;
      w_holdoff_next    = '0;
      w_blink_cnt_next  = '0;
      w_flash_cnt_next  = '0;
      w_toggle_cnt_next = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_next      = ST_SELECT;
          w_sel_next        = 2'd0;
          w_posy_next       = POSY0;
          w_isplay_next     = 1'b1;
          w_blink_cnt_next  = '0;
          w_holdoff_next    = '0;
          w_pend_valid_next = 1'b0;
        end
        ST_SELECT: begin
          if (w_enter_edge) begin
            w_state_next      = ST_FLASH;
            w_pend_valid_next = 1'b0;
            w_isplay_next     = 1'b1;
            w_flash_cnt_next  = '0;
            w_toggle_cnt_next = '0;
          end else begin
            if (frame_tick) begin
              if (r_pend_valid && w_target_ok) begin
                w_apply           = 1'b1;
                w_sel_next        = w_target_sel;
                w_posy_next       = f_posy(w_target_sel);
                w_pend_valid_next = 1'b0;
                w_holdoff_next    = HW'(HOLDOFF_FRAMES);
                w_blink_cnt_next  = '0;
                w_isplay_next     = 1'b1;
              end else begin
                // An out-of-range move is dropped here without touching the blink phase.
                w_pend_valid_next = 1'b0;
                if (r_holdoff != '0)
                  w_holdoff_next = r_holdoff - HW'(1);
                if (r_blink_cnt == BW'(BLINK_FRAMES - 1)) begin
                  w_blink_cnt_next = '0;
                  w_isplay_next    = ~r_isplay;
                end else begin
                  w_blink_cnt_next = r_blink_cnt + BW'(1);
                end
              end
            end
            if (!w_apply && (w_up_edge ^ w_down_edge) && (r_holdoff == '0)) begin
              w_pend_valid_next = 1'b1;
              w_pend_down_next  = w_down_edge;
            end
          end
        end
        ST_FLASH: begin
          if (frame_tick) begin
            if (r_flash_cnt == FW'(FLASH_FRAMES - 1)) begin
              w_flash_cnt_next = '0;
              w_isplay_next    = ~r_isplay;
              if (r_toggle_cnt == CW'(FLASH_COUNT - 1)) begin
                w_state_next      = ST_DONE;
                w_confirm_next    = 1'b1;
                w_toggle_cnt_next = '0;
              end else begin
                w_toggle_cnt_next = r_toggle_cnt + CW'(1);
              end
            end else begin
              w_flash_cnt_next = r_flash_cnt + FW'(1);
            end
          end
        end
        ST_DONE: begin
          w_isplay_next = 1'b1;
        end
        default: begin
          w_state_next = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_sel         <= 2'd0;
      r_posy        <= POSY0;
      r_isplay      <= 1'b0;
      r_confirm     <= 1'b0;
      r_pend_valid  <= 1'b0;
      r_pend_down   <= 1'b0;
      r_holdoff     <= '0;
      r_blink_cnt   <= '0;
      r_flash_cnt   <= '0;
      r_toggle_cnt  <= '0;
      r_key_up_q    <= 1'b0;
      r_key_down_q  <= 1'b0;
      r_key_enter_q <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_sel         <= w_sel_next;
      r_posy        <= w_posy_next;
      r_isplay      <= w_isplay_next;
      r_confirm     <= w_confirm_next;
      r_pend_valid  <= w_pend_valid_next;
      r_pend_down   <= w_pend_down_next;
      r_holdoff     <= w_holdoff_next;
      r_blink_cnt   <= w_blink_cnt_next;
      r_flash_cnt   <= w_flash_cnt_next;
      r_toggle_cnt  <= w_toggle_cnt_next;
      r_key_up_q    <= key_up;
      r_key_down_q  <= key_down;
      r_key_enter_q <= key_enter;
    end
  end

  assign posx    = 10'(BASE_X);
  assign posy    = r_posy;
  assign isplay  = r_isplay;
  assign sel     = r_sel;
  assign confirm = r_confirm;
  assign busy    = (r_state == ST_FLASH);

endmodule

// File: tb/tb_menu_cursor_ctrl.sv
// Directed bench for menu_cursor_ctrl: observed vector is {sel, posy, isplay, busy, confirm}.
// Expectations follow MENU_WRAP_EN when the bench is built with that macro.
module tb_menu_cursor_ctrl;
  logic       clk = 1'b0;
  logic       rst, frame_tick, menu_active, key_up, key_down, key_enter;
  logic [9:0] posx;
  logic [8:0] posy;
  logic       isplay, confirm, busy;
  logic [1:0] sel;
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  menu_cursor_ctrl dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .menu_active(menu_active),
    .key_up(key_up), .key_down(key_down), .key_enter(key_enter),
    .posx(posx), .posy(posy), .isplay(isplay), .sel(sel), .confirm(confirm), .busy(busy)
  );

  wire [13:0] obs = {sel, posy, isplay, busy, confirm};

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
    end
  endtask

  task automatic press(input logic u, input logic d, input logic e);
    key_up = u; key_down = d; key_enter = e;
    @(negedge clk);
    key_up = 1'b0; key_down = 1'b0; key_enter = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; frame_tick = 1'b0; menu_active = 1'b0;
    key_up = 1'b0; key_down = 1'b0; key_enter = 1'b0;
    cyc(3);
    n_cmp++; if (obs !== {2'd0, 9'd200, 3'b000}) begin n_bad++; $display("FAIL reset_outs: got %h required %h", obs, {2'd0, 9'd200, 3'b000}); end else $display("ok reset_outs %h", obs);
    n_cmp++; if (posx !== 10'd284) begin n_bad++; $display("FAIL reset_posx: got %0d required 284", posx); end else $display("ok reset_posx %0d", posx);
    rst = 1'b0;
    cyc(1);
  endtask

  task automatic test_select_blink();
    menu_active = 1'b1;
    cyc(1);
    n_cmp++; if (obs !== {2'd0, 9'd200, 3'b100}) begin n_bad++; $display("FAIL enter_select: got %h required %h", obs, {2'd0, 9'd200, 3'b100}); end else $display("ok enter_select %h", obs);
    n_cmp++; if (posx !== 10'd284) begin n_bad++; $display("FAIL select_posx: got %0d required 284", posx); end else $display("ok select_posx %0d", posx);
    tick(29);
    n_cmp++; if (obs !== {2'd0, 9'd200, 3'b100}) begin n_bad++; $display("FAIL blink_29: got %h required %h", obs, {2'd0, 9'd200, 3'b100}); end else $display("ok blink_29 %h", obs);
    tick(1);
    n_cmp++; if (obs !== {2'd0, 9'd200, 3'b000}) begin n_bad++; $display("FAIL blink_30: got %h required %h", obs, {2'd0, 9'd200, 3'b000}); end else $display("ok blink_30 %h", obs);
    tick(30);
    n_cmp++; if (obs !== {2'd0, 9'd200, 3'b100}) begin n_bad++; $display("FAIL blink_60: got %h required %h", obs, {2'd0, 9'd200, 3'b100}); end else $display("ok blink_60 %h", obs);
  endtask

  task automatic test_move();
    press(1'b0, 1'b1, 1'b0);
    n_cmp++; if (obs !== {2'd0, 9'd200, 3'b100}) begin n_bad++; $display("FAIL move_wait_tick: got %h required %h", obs, {2'd0, 9'd200, 3'b100}); end else $display("ok move_wait_tick %h", obs);
    tick(1);
    n_cmp++; if (obs !== {2'd1, 9'd248, 3'b100}) begin n_bad++; $display("FAIL move_down1: got %h required %h", obs, {2'd1, 9'd248, 3'b100}); end else $display("ok move_down1 %h", obs);
    press(1'b0, 1'b1, 1'b0);
    tick(8);
    n_cmp++; if (obs !== {2'd1, 9'd248, 3'b100}) begin n_bad++; $display("FAIL holdoff_ignore: got %h required %h", obs, {2'd1, 9'd248, 3'b100}); end else $display("ok holdoff_ignore %h", obs);
    press(1'b0, 1'b1, 1'b0);
    tick(1);
    n_cmp++; if (obs !== {2'd2, 9'd296, 3'b100}) begin n_bad++; $display("FAIL move_down2: got %h required %h", obs, {2'd2, 9'd296, 3'b100}); end else $display("ok move_down2 %h", obs);
  endtask

  task automatic test_end_of_range();
    tick(8);
    press(1'b0, 1'b1, 1'b0);
    tick(1);
`ifdef MENU_WRAP_EN
    n_cmp++; if (obs !== {2'd0, 9'd200, 3'b100}) begin n_bad++; $display("FAIL wrap_down: got %h required %h", obs, {2'd0, 9'd200, 3'b100}); end else $display("ok wrap_down %h", obs);
`else
    n_cmp++; if (obs !== {2'd2, 9'd296, 3'b100}) begin n_bad++; $display("FAIL saturate_down: got %h required %h", obs, {2'd2, 9'd296, 3'b100}); end else $display("ok saturate_down %h", obs);
    tick(20);
    n_cmp++; if (obs !== {2'd2, 9'd296, 3'b100}) begin n_bad++; $display("FAIL sat_phase_29: got %h required %h", obs, {2'd2, 9'd296, 3'b100}); end else $display("ok sat_phase_29 %h", obs);
    tick(1);
    n_cmp++; if (obs !== {2'd2, 9'd296, 3'b000}) begin n_bad++; $display("FAIL sat_phase_30: got %h required %h", obs, {2'd2, 9'd296, 3'b000}); end else $display("ok sat_phase_30 %h", obs);
`endif
  endtask

  task automatic test_menu_exit();
    menu_active = 1'b0;
    cyc(1);
    n_cmp++; if (obs !== {2'd0, 9'd200, 3'b000}) begin n_bad++; $display("FAIL menu_exit: got %h required %h", obs, {2'd0, 9'd200, 3'b000}); end else $display("ok menu_exit %h", obs);
    menu_active = 1'b1;
    cyc(1);
    n_cmp++; if (obs !== {2'd0, 9'd200, 3'b100}) begin n_bad++; $display("FAIL menu_reenter: got %h required %h", obs, {2'd0, 9'd200, 3'b100}); end else $display("ok menu_reenter %h", obs);
  endtask

  task automatic test_up_and_simultaneous();
    press(1'b0, 1'b1, 1'b0);
    tick(1);
    n_cmp++; if (obs !== {2'd1, 9'd248, 3'b100}) begin n_bad++; $display("FAIL down_again: got %h required %h", obs, {2'd1, 9'd248, 3'b100}); end else $display("ok down_again %h", obs);
    tick(8);
    press(1'b1, 1'b0, 1'b0);
    tick(1);
    n_cmp++; if (obs !== {2'd0, 9'd200, 3'b100}) begin n_bad++; $display("FAIL move_up: got %h required %h", obs, {2'd0, 9'd200, 3'b100}); end else $display("ok move_up %h", obs);
    tick(8);
    press(1'b0, 1'b1, 1'b0);
    tick(1);
    tick(8);
    press(1'b1, 1'b1, 1'b0);
    tick(1);
    n_cmp++; if (obs !== {2'd1, 9'd248, 3'b100}) begin n_bad++; $display("FAIL up_down_same: got %h required %h", obs, {2'd1, 9'd248, 3'b100}); end else $display("ok up_down_same %h", obs);
  endtask

  task automatic test_flash();
    logic [13:0] exp_v;
    press(1'b0, 1'b1, 1'b1);
    n_cmp++; if (obs !== {2'd1, 9'd248, 3'b110}) begin n_bad++; $display("FAIL flash_entry: got %h required %h", obs, {2'd1, 9'd248, 3'b110}); end else $display("ok flash_entry %h", obs);
    for (int k = 1; k <= 24; k++) begin
      if (k == 10) press(1'b1, 1'b0, 1'b0);
      tick(1);
      if (k == 24) exp_v = {2'd1, 9'd248, 3'b101};
      else exp_v = {2'd1, 9'd248, (((k / 4) % 2) == 0) ? 1'b1 : 1'b0, 2'b10};
      n_cmp++; if (obs !== exp_v) begin n_bad++; $display("FAIL flash_tick%0d: got %h required %h", k, obs, exp_v); end else $display("ok flash_tick%0d %h", k, obs);
    end
    cyc(1);
    n_cmp++; if (obs !== {2'd1, 9'd248, 3'b100}) begin n_bad++; $display("FAIL confirm_one_cycle: got %h required %h", obs, {2'd1, 9'd248, 3'b100}); end else $display("ok confirm_one_cycle %h", obs);
    press(1'b0, 1'b1, 1'b0);
    tick(1);
    press(1'b1, 1'b0, 1'b1);
    tick(1);
    n_cmp++; if (obs !== {2'd1, 9'd248, 3'b100}) begin n_bad++; $display("FAIL done_keys_ignored: got %h required %h", obs, {2'd1, 9'd248, 3'b100}); end else $display("ok done_keys_ignored %h", obs);
  endtask

  task automatic test_exit_mid_flash();
    menu_active = 1'b0;
    cyc(1);
    menu_active = 1'b1;
    cyc(1);
    press(1'b0, 1'b1, 1'b0);
    tick(1);
    press(1'b0, 1'b0, 1'b1);
    n_cmp++; if (obs !== {2'd1, 9'd248, 3'b110}) begin n_bad++; $display("FAIL flash2_entry: got %h required %h", obs, {2'd1, 9'd248, 3'b110}); end else $display("ok flash2_entry %h", obs);
    tick(23);
    // Final flash tick arrives together with menu exit: exit must win, no confirm.
    menu_active = 1'b0;
    frame_tick = 1'b1;
    cyc(1);
    frame_tick = 1'b0;
    n_cmp++; if (obs !== {2'd0, 9'd200, 3'b000}) begin n_bad++; $display("FAIL flash_abort: got %h required %h", obs, {2'd0, 9'd200, 3'b000}); end else $display("ok flash_abort %h", obs);
  endtask

  task automatic test_reset_cases();
    menu_active = 1'b1;
    cyc(1);
    press(1'b0, 1'b1, 1'b0);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    n_cmp++; if (obs !== {2'd0, 9'd200, 3'b000}) begin n_bad++; $display("FAIL rst_select: got %h required %h", obs, {2'd0, 9'd200, 3'b000}); end else $display("ok rst_select %h", obs);
    cyc(1);
    tick(1);
    n_cmp++; if (obs !== {2'd0, 9'd200, 3'b100}) begin n_bad++; $display("FAIL rst_pending_dropped: got %h required %h", obs, {2'd0, 9'd200, 3'b100}); end else $display("ok rst_pending_dropped %h", obs);
    press(1'b0, 1'b0, 1'b1);
    tick(3);
    rst = 1'b1;
    cyc(1);
    n_cmp++; if (obs !== {2'd0, 9'd200, 3'b000}) begin n_bad++; $display("FAIL rst_flash: got %h required %h", obs, {2'd0, 9'd200, 3'b000}); end else $display("ok rst_flash %h", obs);
    rst = 1'b0;
    cyc(2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_select_blink();
    test_move();
    test_end_of_range();
    test_menu_exit();
    test_up_and_simultaneous();
    test_flash();
    test_exit_mid_flash();
    test_reset_cases();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
